// File: rtl/ul_srch_900k_ctrl_pkg.sv
// Shared definitions for the uplink search 900 kHz segmentation sequencer.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package ul_srch_900k_ctrl_pkg;

    // Subcarrier spacing codes as programmed in the search config bank
    localparam logic [1:0] SCS_OFF = 2'd0;
    localparam logic [1:0] SCS_5K  = 2'd1;
    localparam logic [1:0] SCS_15K = 2'd2;
    localparam logic [1:0] SCS_30K = 2'd3;

    // REs per 900 kHz segment for each spacing
    localparam int SEGLEN_5K  = 180;
    localparam int SEGLEN_15K = 60;
    localparam int SEGLEN_30K = 30;

    // A run may not extend past this many REs from index 0
    localparam int MAX_RE_NUM = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Segment length for a spacing code; 0 for the "off" code
    function automatic logic [7:0] seglen_of(input logic [1:0] scs);
        logic [7:0] len;
        case (scs)
            SCS_5K:  len = 8'(SEGLEN_5K);
            SCS_15K: len = 8'(SEGLEN_15K);
            SCS_30K: len = 8'(SEGLEN_30K);
            default: len = 8'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ul_srch_900k.sv
// Maps an RE index to its 900 kHz segment number and in-segment offset.
// Latency: purely combinational.
// Backpressure: none; output follows input.
module ul_srch_900k
    import ul_srch_900k_ctrl_pkg::*;
#(
    parameter int IDX_W = 12
) (
    input  logic [1:0]       scs,
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       seg,
    output logic [7:0]       mod
);

    // Constant divisors per spacing keep each branch a fixed-divide network
    always_comb begin
        seg = '0;
        mod = '0;
        case (scs)
            SCS_5K: begin
                seg = 8'(idx / IDX_W'(SEGLEN_5K));
                mod = 8'(idx % IDX_W'(SEGLEN_5K));
            end
            SCS_15K: begin
                seg = 8'(idx / IDX_W'(SEGLEN_15K));
                mod = 8'(idx % IDX_W'(SEGLEN_15K));
            end
            SCS_30K: begin
                seg = 8'(idx / IDX_W'(SEGLEN_30K));
                mod = 8'(idx % IDX_W'(SEGLEN_30K));
            end
            default: begin
                seg = '0;
                mod = '0;
            end
        endcase
    end

endmodule

// File: rtl/ul_srch_900k_ctrl.sv
// Walks a configured RE range and streams segment/offset/flags per RE.
// Latency: start sampled at edge k gives first beat visible after edge k+1.
// Backpressure: valid/ready; beat fields and index/count hold while out_rdy=0.
module ul_srch_900k_ctrl
    import ul_srch_900k_ctrl_pkg::*;
#(
    parameter int IDX_W = 12,
    parameter int NUM_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [1:0]       cfg_scs,
    input  logic [IDX_W-1:0] cfg_re_start,
    input  logic [NUM_W-1:0] cfg_re_num,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [IDX_W-1:0] out_re_index,
    output logic [7:0]       out_seg,
    output logic [7:0]       out_mod,
    output logic             out_sos,
    output logic             out_eos,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       scs_q;
    logic [IDX_W-1:0] idx;
    logic [NUM_W-1:0] cnt;
    logic             first_q;
    logic             err_q;

    logic [7:0]       map_seg;
    logic [7:0]       map_mod;
    logic [7:0]       seglen;
    logic [NUM_W:0]   end_sum;
    logic             cfg_illegal;
    logic             load;
    logic             cnt_is_one;
    logic             handshake;

    ul_srch_900k #(
        .IDX_W (IDX_W)
    ) u_map (
        .scs (scs_q),
        .idx (idx),
        .seg (map_seg),
        .mod (map_mod)
    );

    // One bit wider than the count so start+num cannot overflow the check
    assign end_sum     = (NUM_W+1)'(cfg_re_start) + (NUM_W+1)'(cfg_re_num);
    assign cfg_illegal = (cfg_scs == SCS_OFF) || (end_sum > (NUM_W+1)'(MAX_RE_NUM));

    assign seglen      = seglen_of(scs_q);
    assign cnt_is_one  = (cnt == NUM_W'(1));
    assign handshake   = out_vld && out_rdy;
    assign load        = (state == ST_RUN) && (!out_vld || out_rdy) && (cnt != '0);

    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign err         = (state == ST_DONE) && err_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    if (cfg_illegal || (cfg_re_num == '0)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (load && cnt_is_one) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (handshake) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (cfg_abort) begin
            state_nxt = ST_IDLE;
        end
    end

    // Config latch, RE walk counters and the registered output beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scs_q        <= '0;
            idx          <= '0;
            cnt          <= '0;
            first_q      <= 1'b0;
            err_q        <= 1'b0;
            out_vld      <= 1'b0;
            out_re_index <= '0;
            out_seg      <= '0;
            out_mod      <= '0;
            out_sos      <= 1'b0;
            out_eos      <= 1'b0;
            out_last     <= 1'b0;
        end else if (cfg_abort) begin
            first_q  <= 1'b0;
            err_q    <= 1'b0;
            out_vld  <= 1'b0;
            out_sos  <= 1'b0;
            out_eos  <= 1'b0;
            out_last <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        scs_q   <= cfg_scs;
                        idx     <= cfg_re_start;
                        cnt     <= cfg_re_num;
                        first_q <= 1'b1;
                        err_q   <= cfg_illegal;
                    end
                end
                ST_RUN: begin
                    if (load) begin
                        out_vld      <= 1'b1;
                        out_re_index <= idx;
                        out_seg      <= map_seg;
                        out_mod      <= map_mod;
                        // First beat of a run opens a segment even mid-segment
                        out_sos      <= first_q || (map_mod == 8'd0);
                        // Final beat closes the segment even if it is partial
                        out_eos      <= cnt_is_one || (map_mod == (seglen - 8'd1));
                        out_last     <= cnt_is_one;
                        first_q      <= 1'b0;
                        idx          <= idx + IDX_W'(1);
                        cnt          <= cnt - NUM_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (handshake) begin
                        out_vld  <= 1'b0;
                        out_sos  <= 1'b0;
                        out_eos  <= 1'b0;
                        out_last <= 1'b0;
                    end
                end
                ST_DONE: begin
                    err_q <= 1'b0;
                end
                default: begin
                    err_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ul_srch_900k_ctrl.sv
module tb_ul_srch_900k_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cfg_start;
    logic        cfg_abort;
    logic [1:0]  cfg_scs;
    logic [11:0] cfg_re_start;
    logic [12:0] cfg_re_num;
    logic        out_vld;
    logic        out_rdy;
    logic [11:0] out_re_index;
    logic [7:0]  out_seg;
    logic [7:0]  out_mod;
    logic        out_sos;
    logic        out_eos;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;

    int tests_run = 0;
    int failed    = 0;

    typedef struct packed {
        logic [11:0] idx;
        logic [7:0]  seg;
        logic [7:0]  mod;
        logic        sos;
        logic        eos;
        logic        last;
    } beat_t;

    beat_t got_q[$];
    int    done_cnt, err_cnt, done_cyc, first_vld_cyc, last_hs_cyc, stab_viol;
    bit    timeout_flag, aborted;
    logic  ab_vld, ab_busy, ab_done;

    ul_srch_900k_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_start    (cfg_start),
        .cfg_abort    (cfg_abort),
        .cfg_scs      (cfg_scs),
        .cfg_re_start (cfg_re_start),
        .cfg_re_num   (cfg_re_num),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_re_index (out_re_index),
        .out_seg      (out_seg),
        .out_mod      (out_mod),
        .out_sos      (out_sos),
        .out_eos      (out_eos),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what beat i of a run must look like, straight from segment arithmetic
    function automatic beat_t model_beat(input int scs, input int st, input int num, input int i);
        beat_t b;
        int    len;
        int    ix;
        len    = (scs == 1) ? 180 : (scs == 2) ? 60 : 30;
        ix     = st + i;
        b.idx  = 12'(ix);
        b.seg  = 8'(ix / len);
        b.mod  = 8'(ix % len);
        b.sos  = (i == 0) || (ix % len == 0);
        b.eos  = (i == num - 1) || (ix % len == len - 1);
        b.last = (i == num - 1);
        return b;
    endfunction

    // Issues one start and observes the run; rdy_pct<0 selects the 1,0,0 ready pattern
    task automatic run_cfg(input logic [1:0] scs, input logic [11:0] st, input logic [12:0] num,
                           input int rdy_pct, input int abort_at);
        beat_t cur;
        beat_t prev;
        bit    prev_hold;
        bit    ab_pending;
        bit    r;
        int    end_c;
        int    c;
        got_q.delete();
        done_cnt = 0; err_cnt = 0; done_cyc = -1; first_vld_cyc = -1; last_hs_cyc = -1;
        stab_viol = 0; timeout_flag = 0; aborted = 0; ab_pending = 0;
        ab_vld = 1'bx; ab_busy = 1'bx; ab_done = 1'bx;
        prev = '0; prev_hold = 0; end_c = -1;
        @(negedge clk);
        cfg_start = 1'b1; cfg_scs = scs; cfg_re_start = st; cfg_re_num = num; out_rdy = 1'b0;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_scs = 2'($urandom); cfg_re_start = 12'($urandom); cfg_re_num = 13'($urandom);
        for (c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk);
            cur = {out_re_index, out_seg, out_mod, out_sos, out_eos, out_last};
            if (prev_hold && (!out_vld || cur != prev)) stab_viol++;
            if (out_vld && first_vld_cyc < 0) first_vld_cyc = c;
            if (done) begin done_cnt++; done_cyc = c; end
            if (err) err_cnt++;
            if (ab_pending) begin
                ab_vld = out_vld; ab_busy = busy; ab_done = done;
                cfg_abort = 1'b0; ab_pending = 0; end_c = c + 5;
            end
            if (rdy_pct < 0) r = (c % 3 == 0);
            else             r = ($urandom_range(0, 99) < rdy_pct);
            // Starts while the run is mid-stream must be ignored
            cfg_start = (out_vld && !out_last && $urandom_range(0, 7) == 0);
            if (abort_at >= 0 && !aborted && out_vld && got_q.size() == abort_at) begin
                cfg_abort = 1'b1; cfg_start = 1'b1; r = 1'b0; aborted = 1; ab_pending = 1;
            end
            out_rdy = r;
            if (out_vld && r) begin got_q.push_back(cur); last_hs_cyc = c; end
            prev_hold = out_vld && !r;
            prev = cur;
            if (done && end_c < 0) end_c = c + 3;
            if (end_c >= 0 && c >= end_c) break;
        end
        if (c >= 3000) timeout_flag = 1;
        cfg_start = 1'b0; cfg_abort = 1'b0; out_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_start = 0; cfg_abort = 0; cfg_scs = 0; cfg_re_start = 0; cfg_re_num = 0; out_rdy = 0;
        #3;
        tests_run++;
        if ({out_vld, out_re_index, out_seg, out_mod, out_sos, out_eos, out_last, busy, done, err} !== '0) begin
            failed++;
            $display("FAIL reset_outputs got vld=%b idx=%0d seg=%0d mod=%0d busy=%b done=%b err=%b required all 0",
                     out_vld, out_re_index, out_seg, out_mod, busy, done, err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({out_vld, busy, done, err} !== 4'b0) begin
            failed++;
            $display("FAIL idle_after_reset got vld=%b busy=%b done=%b err=%b required 0000", out_vld, busy, done, err);
        end
    endtask

    task automatic test_walk();
        int scs_t[$], st_t[$], num_t[$], pct_t[$];
        int n;
        beat_t e;
        // Directed rows first, then randomized legal configs
        scs_t = '{3, 1, 2, 3, 2};  st_t = '{0, 250, 100, 4090, 4095};
        num_t = '{65, 20, 3, 6, 1}; pct_t = '{100, 100, -1, 100, 60};
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(1, 40);
            scs_t.push_back($urandom_range(1, 3));
            num_t.push_back(n);
            st_t.push_back($urandom_range(0, 4096 - n));
            pct_t.push_back($urandom_range(30, 100));
        end
        for (int t = 0; t < scs_t.size(); t++) begin
            run_cfg(2'(scs_t[t]), 12'(st_t[t]), 13'(num_t[t]), pct_t[t], -1);
            tests_run++;
            if (timeout_flag) begin failed++; $display("FAIL walk%0d_timeout no done within budget", t); end
            tests_run++;
            if (got_q.size() != num_t[t]) begin
                failed++;
                $display("FAIL walk%0d_beats got %0d handshakes required %0d", t, got_q.size(), num_t[t]);
            end
            for (int i = 0; i < got_q.size() && i < num_t[t]; i++) begin
                e = model_beat(scs_t[t], st_t[t], num_t[t], i);
                tests_run++;
                if (got_q[i] !== e) begin
                    failed++;
                    $display("FAIL walk%0d_beat%0d got idx=%0d seg=%0d mod=%0d sos/eos/last=%b%b%b required idx=%0d seg=%0d mod=%0d sos/eos/last=%b%b%b",
                             t, i, got_q[i].idx, got_q[i].seg, got_q[i].mod, got_q[i].sos, got_q[i].eos, got_q[i].last,
                             e.idx, e.seg, e.mod, e.sos, e.eos, e.last);
                end
            end
            tests_run++;
            if (first_vld_cyc != 1) begin
                failed++; $display("FAIL walk%0d_latency got first valid at cycle %0d required 1", t, first_vld_cyc);
            end
            tests_run++;
            if (stab_viol != 0) begin
                failed++; $display("FAIL walk%0d_hold got %0d unstable stalled cycles required 0", t, stab_viol);
            end
            tests_run++;
            if (done_cnt != 1 || err_cnt != 0 || done_cyc != last_hs_cyc + 1) begin
                failed++;
                $display("FAIL walk%0d_done got done=%0d err=%0d at cycle %0d required 1 pulse err=0 at cycle %0d",
                         t, done_cnt, err_cnt, done_cyc, last_hs_cyc + 1);
            end
            if (pct_t[t] == 100) begin
                tests_run++;
                if (done_cyc != num_t[t] + 1) begin
                    failed++; $display("FAIL walk%0d_full_rate got done at cycle %0d required %0d", t, done_cyc, num_t[t] + 1);
                end
            end
        end
    endtask

    task automatic test_errors();
        int scs_t[$], st_t[$], num_t[$], err_t[$];
        scs_t = '{0, 3, 3, 1, 0};
        st_t  = '{0, 4090, 0, 4095, 100};
        num_t = '{5, 7, 0, 2, 0};
        err_t = '{1, 1, 0, 1, 1};
        for (int t = 0; t < scs_t.size(); t++) begin
            run_cfg(2'(scs_t[t]), 12'(st_t[t]), 13'(num_t[t]), 100, -1);
            tests_run++;
            if (first_vld_cyc != -1 || got_q.size() != 0) begin
                failed++; $display("FAIL err%0d_no_beats got first valid at cycle %0d required none", t, first_vld_cyc);
            end
            tests_run++;
            if (done_cnt != 1 || done_cyc != 0) begin
                failed++; $display("FAIL err%0d_done got %0d pulses at cycle %0d required 1 at cycle 0", t, done_cnt, done_cyc);
            end
            tests_run++;
            if (err_cnt != err_t[t]) begin
                failed++; $display("FAIL err%0d_err got %0d err cycles required %0d", t, err_cnt, err_t[t]);
            end
        end
    endtask

    task automatic test_abort();
        beat_t e;
        run_cfg(2'd3, 12'd0, 13'd100, 100, 10);
        tests_run++;
        if (!aborted || ab_vld !== 1'b0 || ab_busy !== 1'b0 || ab_done !== 1'b0) begin
            failed++;
            $display("FAIL abort_next_edge got aborted=%0d vld=%b busy=%b done=%b required 1 0 0 0", aborted, ab_vld, ab_busy, ab_done);
        end
        tests_run++;
        if (done_cnt != 0 || err_cnt != 0) begin
            failed++; $display("FAIL abort_no_done got done=%0d err=%0d required 0 0", done_cnt, err_cnt);
        end
        tests_run++;
        if (got_q.size() != 10) begin
            failed++; $display("FAIL abort_beats got %0d required 10", got_q.size());
        end
        run_cfg(2'd3, 12'd0, 13'd100, 100, -1);
        tests_run++;
        if (got_q.size() != 100 || done_cnt != 1) begin
            failed++; $display("FAIL replay_count got %0d beats %0d done required 100 1", got_q.size(), done_cnt);
        end
        for (int i = 0; i < got_q.size() && i < 100; i += 9) begin
            e = model_beat(3, 0, 100, i);
            tests_run++;
            if (got_q[i] !== e) begin
                failed++; $display("FAIL replay_beat%0d got idx=%0d mod=%0d required idx=%0d mod=%0d",
                                   i, got_q[i].idx, got_q[i].mod, e.idx, e.mod);
            end
        end
    endtask

    task automatic test_reset_midrun();
        bit seen;
        seen = 0;
        @(negedge clk);
        cfg_start = 1'b1; cfg_scs = 2'd3; cfg_re_start = 12'd0; cfg_re_num = 13'd100; out_rdy = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (out_vld && out_re_index == 12'd5) seen = 1;
            else @(negedge clk);
        end
        tests_run++;
        if (!seen) begin failed++; $display("FAIL midrun_reach_beat5 got no beat 5 within 50 cycles required beat 5"); end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_vld, out_re_index, out_seg, out_mod, out_sos, out_eos, out_last, busy, done, err} !== '0) begin
            failed++;
            $display("FAIL midrun_reset got vld=%b idx=%0d mod=%0d busy=%b done=%b required all 0",
                     out_vld, out_re_index, out_mod, busy, done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; out_rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if ({out_vld, busy, done} !== 3'b0) begin
                failed++; $display("FAIL midrun_after got vld=%b busy=%b done=%b required 000", out_vld, busy, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_errors();
        test_abort();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
